// File: rtl/sm_run_ctrl.sv
// rtl/sm_run_ctrl.sv - run/halt/single-step sequencer with one hardware breakpoint
// Optional retired-instruction counter enabled by SM_RUN_CTRL_PERF_EN.
module sm_run_ctrl #(
    parameter int STEP_W    = 16,
    parameter int CNT_W     = 32,
    parameter bit RESET_RUN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [31:0]       cmd_arg,
    input  logic [31:0]       pc_i,
    output logic              cpu_en,
    output logic              halted,
    output logic              bp_hit,
    output logic              cmd_err,
    output logic [STEP_W-1:0] step_left,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [1:0] OP_HALT   = 2'd0;
    localparam logic [1:0] OP_RUN    = 2'd1;
    localparam logic [1:0] OP_STEP   = 2'd2;
    localparam logic [1:0] OP_SET_BP = 2'd3;
    localparam state_t     RESET_STATE = RESET_RUN ? ST_RUN : ST_HALT;

    state_t              state, state_nxt;
    logic [STEP_W-1:0]   step_left_nxt;
    logic [31:0]         bp_addr, bp_addr_nxt;
    logic                bp_valid, bp_valid_nxt;
    logic                bp_hit_nxt;
    logic                cmd_err_nxt;
    logic                skip_bp, skip_bp_nxt;
    logic                run_en;
    logic                accept;
    logic                bp_match;
    logic [STEP_W-1:0]   step_n;

    assign cmd_ready = rst_n;
    assign accept    = cmd_valid & cmd_ready;
    assign step_n    = cmd_arg[STEP_W-1:0];
    assign bp_match  = bp_valid & (pc_i == bp_addr) & ~skip_bp;
    assign cpu_en    = rst_n & run_en;
    assign halted    = (state == ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET_STATE;
            step_left <= '0;
            bp_addr   <= '0;
            bp_valid  <= 1'b0;
            bp_hit    <= 1'b0;
            cmd_err   <= 1'b0;
            skip_bp   <= 1'b0;
        end else begin
            state     <= state_nxt;
            step_left <= step_left_nxt;
            bp_addr   <= bp_addr_nxt;
            bp_valid  <= bp_valid_nxt;
            bp_hit    <= bp_hit_nxt;
            cmd_err   <= cmd_err_nxt;
            skip_bp   <= skip_bp_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        step_left_nxt = step_left;
        bp_addr_nxt   = bp_addr;
        bp_valid_nxt  = bp_valid;
        bp_hit_nxt    = bp_hit;
        cmd_err_nxt   = 1'b0;
        skip_bp_nxt   = skip_bp;
        run_en        = 1'b0;

        if (accept && (cmd_op == OP_RUN || (cmd_op == OP_STEP && step_n != '0)))
            bp_hit_nxt = 1'b0;

        // All-ones is reserved as the "no breakpoint" address
        if (accept && cmd_op == OP_SET_BP) begin
            if (cmd_arg == 32'hFFFF_FFFF) begin
                bp_valid_nxt = 1'b0;
            end else begin
                bp_addr_nxt  = cmd_arg;
                bp_valid_nxt = 1'b1;
            end
        end

        case (state)
            ST_HALT: begin
                if (accept && cmd_op == OP_RUN) begin
                    state_nxt   = ST_RUN;
                    skip_bp_nxt = 1'b1;
                end else if (accept && cmd_op == OP_STEP && step_n != '0) begin
                    state_nxt     = ST_STEP;
                    step_left_nxt = step_n;
                end
            end
            ST_RUN: begin
                run_en      = ~bp_match;
                skip_bp_nxt = 1'b0;
                if (bp_match) begin
                    state_nxt  = ST_HALT;
                    bp_hit_nxt = 1'b1;
                end
                if (accept && cmd_op == OP_HALT)
                    state_nxt = ST_HALT;
                if (accept && (cmd_op == OP_RUN || cmd_op == OP_STEP))
                    cmd_err_nxt = 1'b1;
            end
            ST_STEP: begin
                run_en = 1'b1;
                if (step_left > STEP_W'(1)) begin
                    step_left_nxt = step_left - STEP_W'(1);
                end else begin
                    step_left_nxt = '0;
                    state_nxt     = ST_HALT;
                end
                if (accept && cmd_op == OP_HALT) begin
                    state_nxt     = ST_HALT;
                    step_left_nxt = '0;
                end
                if (accept && (cmd_op == OP_RUN || cmd_op == OP_STEP))
                    cmd_err_nxt = 1'b1;
            end
            default: begin
                state_nxt = ST_HALT;
            end
        endcase
    end

`ifdef SM_RUN_CTRL_PERF_EN
    logic [CNT_W-1:0] retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retired_q <= '0;
        else if (cpu_en)
            retired_q <= retired_q + CNT_W'(1);
    end

    assign retired = retired_q;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_sm_run_ctrl.sv
// tb/tb_sm_run_ctrl.sv - randomized and directed bench for sm_run_ctrl against a behavioural model
module tb_sm_run_ctrl;

    localparam int STEP_W    = 16;
    localparam int CNT_W     = 32;
    localparam bit RESET_RUN = 1'b1;

    localparam logic [1:0] C_HALT = 2'd0;
    localparam logic [1:0] C_RUN  = 2'd1;
    localparam logic [1:0] C_STEP = 2'd2;
    localparam logic [1:0] C_BP   = 2'd3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd0;
    logic [31:0]       cmd_arg = 32'd0;
    logic [31:0]       pc_i = 32'd0;
    logic              cpu_en;
    logic              halted;
    logic              bp_hit;
    logic              cmd_err;
    logic [STEP_W-1:0] step_left;
    logic [CNT_W-1:0]  retired;

    sm_run_ctrl #(
        .STEP_W    (STEP_W),
        .CNT_W     (CNT_W),
        .RESET_RUN (RESET_RUN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .pc_i      (pc_i),
        .cpu_en    (cpu_en),
        .halted    (halted),
        .bp_hit    (bp_hit),
        .cmd_err   (cmd_err),
        .step_left (step_left),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: the core is either stopped, free-running, or owes a number of steps
    typedef enum int {M_STOP, M_FREE, M_OWE} mode_t;
    mode_t        m_mode;
    int           m_owed;
    bit           m_bp_on;
    logic [31:0]  m_bp;
    bit           m_grace;
    bit           m_hit;
    bit           m_err;
    logic [31:0]  m_ret;

    function automatic logic [31:0] exp_retired();
`ifdef SM_RUN_CTRL_PERF_EN
        return m_ret;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        m_mode  = RESET_RUN ? M_FREE : M_STOP;
        m_owed  = 0;
        m_bp_on = 0;
        m_bp    = 32'd0;
        m_grace = 0;
        m_hit   = 0;
        m_err   = 0;
        m_ret   = 32'd0;
    endtask

    function automatic bit model_retires(input logic [31:0] pc);
        if (m_mode == M_OWE) return 1'b1;
        if (m_mode == M_STOP) return 1'b0;
        return !(m_bp_on && pc == m_bp && !m_grace);
    endfunction

    task automatic model_advance(input bit v, input logic [1:0] op, input logic [31:0] arg,
                                 input logic [31:0] pc);
        bit go;
        int n;
        go    = model_retires(pc);
        n     = int'(arg[STEP_W-1:0]);
        m_err = 0;
        if (go) m_ret = m_ret + 32'd1;
        if (v && op == C_BP) begin
            if (arg == 32'hFFFF_FFFF) m_bp_on = 0;
            else begin m_bp = arg; m_bp_on = 1; end
        end
        if (v && (op == C_RUN || (op == C_STEP && n != 0))) m_hit = 0;
        case (m_mode)
            M_STOP: begin
                if (v && op == C_RUN) begin m_mode = M_FREE; m_grace = 1; end
                else if (v && op == C_STEP && n != 0) begin m_mode = M_OWE; m_owed = n; end
            end
            M_FREE: begin
                m_grace = 0;
                if (!go) begin m_mode = M_STOP; m_hit = 1; end
                if (v && op == C_HALT) m_mode = M_STOP;
                if (v && (op == C_RUN || op == C_STEP)) m_err = 1;
            end
            default: begin
                m_owed = m_owed - 1;
                if (v && op == C_HALT) m_owed = 0;
                if (m_owed == 0) m_mode = M_STOP;
                if (v && (op == C_RUN || op == C_STEP)) m_err = 1;
            end
        endcase
    endtask

    task automatic compare_all();
        check_eq("cpu_en",    cpu_en,    model_retires(pc_i));
        check_eq("cmd_ready", cmd_ready, 1'b1);
        check_eq("halted",    halted,    m_mode == M_STOP);
        check_eq("bp_hit",    bp_hit,    m_hit);
        check_eq("cmd_err",   cmd_err,   m_err);
        check_eq("step_left", step_left, m_owed);
        check_eq("retired",   retired,   exp_retired());
    endtask

    task automatic cycle(input bit v, input logic [1:0] op, input logic [31:0] arg,
                         input logic [31:0] pc);
        @(negedge clk);
        cmd_valid = v;
        cmd_op    = op;
        cmd_arg   = arg;
        pc_i      = pc;
        #1;
        compare_all();
        model_advance(v, op, arg, pc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check_eq("rst_cpu_en",    cpu_en,    1'b0);
        check_eq("rst_cmd_ready", cmd_ready, 1'b0);
        check_eq("rst_step_left", step_left, 0);
        check_eq("rst_bp_hit",    bp_hit,    1'b0);
        check_eq("rst_cmd_err",   cmd_err,   1'b0);
        check_eq("rst_retired",   retired,   0);
        check_eq("rst_halted",    halted,    !RESET_RUN);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] arg;
        bit          v;

        do_reset();

        // Free run from reset, no breakpoint
        for (int i = 0; i < 10; i++) cycle(0, C_HALT, 0, 32'd100 + 32'(i));
        @(posedge clk);
        #1;
`ifdef SM_RUN_CTRL_PERF_EN
        check_eq("t1_retired10", retired, 10);
`endif
        check_eq("t1_running", halted, 1'b0);

        // Breakpoint at 5 with pc counting from 0
        cycle(1, C_BP, 32'd5, 32'd200);
        for (int i = 0; i < 8; i++) cycle(0, C_HALT, 0, 32'(i));
        check_eq("t2_halted", halted, 1'b1);
        check_eq("t2_bp_hit", bp_hit, 1'b1);

        // Resume from the breakpoint address
        cycle(1, C_RUN, 0, 32'd5);
        for (int i = 5; i < 9; i++) cycle(0, C_HALT, 0, 32'(i));
        check_eq("t3_running", halted, 1'b0);
        check_eq("t3_bp_clr",  bp_hit, 1'b0);

        // STEP 3 then STEP 0 from halt
        cycle(1, C_HALT, 0, 32'd20);
        cycle(1, C_STEP, 32'd3, 32'd20);
        for (int i = 0; i < 5; i++) cycle(0, C_HALT, 0, 32'd21 + 32'(i));
        check_eq("t4_halted", halted, 1'b1);
        cycle(1, C_STEP, 32'd0, 32'd30);
        for (int i = 0; i < 3; i++) cycle(0, C_HALT, 0, 32'd30);

        // Illegal STEP while running, then HALT aborting a STEP 8
        cycle(1, C_RUN, 0, 32'd40);
        cycle(1, C_STEP, 32'd4, 32'd41);
        cycle(0, C_HALT, 0, 32'd42);
        check_eq("t5_still_run", halted, 1'b0);
        cycle(1, C_HALT, 0, 32'd43);
        cycle(1, C_STEP, 32'd8, 32'd44);
        for (int i = 0; i < 20 && m_owed != 5; i++) cycle(0, C_HALT, 0, 32'd45);
        cycle(1, C_HALT, 0, 32'd46);
        cycle(0, C_HALT, 0, 32'd47);
        check_eq("t5_abort_left", step_left, 0);

        // Reset in the middle of a step sequence with step_left = 7
        cycle(1, C_BP, 32'd60, 32'd50);
        cycle(1, C_STEP, 32'd9, 32'd50);
        for (int i = 0; i < 20 && m_owed != 7; i++) cycle(0, C_HALT, 0, 32'd51);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, C_HALT, 0, 32'd60);

        // Randomized traffic with occasional asynchronous reset
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            v  = ($urandom_range(0, 9) < 3);
            op = 2'($urandom_range(0, 3));
            if (op == C_BP)
                arg = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 7));
            else
                arg = 32'($urandom_range(0, 5));
            cycle(v, op, arg, 32'($urandom_range(0, 7)));
        end
        cycle(0, C_HALT, 0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
